teclado_emulador: RTL and testbench

Synthesizable 4x4 matrix-keypad emulator: the key side of the column-scan / row-sense interface that `teclado_matricial` drives. On a start request it "presses" one key by driving the matching row line whenever that key's column is scanned. The press is shaped as contact bounce, then a stable hold, then release bounce. It replaces the physical keypad in hardware loopback tests and lets benches exercise the scanner and debouncer with realistic, reproducible contact behaviour.

---
 rtl/teclado_emulador.sv | 193 +++++++++++++++++++
 tb/tb_teclado_emulador.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/teclado_emulador.sv
// teclado_emulador: key side of a 4x4 matrix keypad.
// On a start request one key is "pressed": its row line is driven back
// whenever its column is scanned, shaped as press bounce, a stable hold
// and release bounce. Bounce comes from an LFSR reseeded on every reset,
// so the contact pattern repeats exactly after each reset.
module teclado_emulador #(
    parameter int BOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] key_code,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       busy,
    output logic       done,
    output logic       pressed
);

    // The phase counter must hold the longer of the two phase lengths
    localparam int MAX_CYCLES = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [7:0]       LFSR_SEED   = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE_PRESS,
        HOLD,
        BOUNCE_RELEASE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]       lfsr;
    logic [7:0]       lfsr_next;
    logic [3:0]       row_mask;
    logic [3:0]       col_mask;
    logic [3:0]       row_mask_dec;
    logic [3:0]       col_mask_dec;
    logic             accept;
    logic             done_next;
    logic             contact;
    logic             in_bounce;

    // Translate a key code into the one-hot row and column of the keypad layout
    always_comb begin
        row_mask_dec = 4'b0000;
        col_mask_dec = 4'b0000;
        case (key_code)
            4'h1: begin row_mask_dec = 4'b0001; col_mask_dec = 4'b0001; end
            4'h2: begin row_mask_dec = 4'b0001; col_mask_dec = 4'b0010; end
            4'h3: begin row_mask_dec = 4'b0001; col_mask_dec = 4'b0100; end
            4'hA: begin row_mask_dec = 4'b0001; col_mask_dec = 4'b1000; end
            4'h4: begin row_mask_dec = 4'b0010; col_mask_dec = 4'b0001; end
            4'h5: begin row_mask_dec = 4'b0010; col_mask_dec = 4'b0010; end
            4'h6: begin row_mask_dec = 4'b0010; col_mask_dec = 4'b0100; end
            4'hB: begin row_mask_dec = 4'b0010; col_mask_dec = 4'b1000; end
            4'h7: begin row_mask_dec = 4'b0100; col_mask_dec = 4'b0001; end
            4'h8: begin row_mask_dec = 4'b0100; col_mask_dec = 4'b0010; end
            4'h9: begin row_mask_dec = 4'b0100; col_mask_dec = 4'b0100; end
            4'hC: begin row_mask_dec = 4'b0100; col_mask_dec = 4'b1000; end
            4'hE: begin row_mask_dec = 4'b1000; col_mask_dec = 4'b0001; end
            4'h0: begin row_mask_dec = 4'b1000; col_mask_dec = 4'b0010; end
            4'hF: begin row_mask_dec = 4'b1000; col_mask_dec = 4'b0100; end
            4'hD: begin row_mask_dec = 4'b1000; col_mask_dec = 4'b1000; end
            default: begin row_mask_dec = 4'b0000; col_mask_dec = 4'b0000; end
        endcase
    end

    // Phase sequencing: each state loads the counter on entry and leaves when it reads 1
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (BOUNCE_CYCLES == 0) begin
                        state_next = HOLD;
                        cnt_next   = HOLD_LOAD;
                    end else begin
                        state_next = BOUNCE_PRESS;
                        cnt_next   = BOUNCE_LOAD;
                    end
                end
            end
            BOUNCE_PRESS: begin
                if (cnt == CNT_ONE) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt == CNT_ONE) begin
                    if (BOUNCE_CYCLES == 0) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = BOUNCE_RELEASE;
                        cnt_next   = BOUNCE_LOAD;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            BOUNCE_RELEASE: begin
                if (cnt == CNT_ONE) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Contact is open when idle, closed when holding and random while bouncing
    always_comb begin
        in_bounce = (state == BOUNCE_PRESS) || (state == BOUNCE_RELEASE);
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        case (state)
            HOLD:           contact = 1'b1;
            BOUNCE_PRESS:   contact = lfsr[0];
            BOUNCE_RELEASE: contact = lfsr[0];
            default:        contact = 1'b0;
        endcase
    end

    // State, phase counter and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= done_next;
        end
    end

    // Bounce generator only moves while bouncing so the pattern is reproducible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (in_bounce) begin
            lfsr <= lfsr_next;
        end
    end

    // Key position is captured at accept so later key_code changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_mask <= 4'b0000;
            col_mask <= 4'b0000;
        end else if (accept) begin
            row_mask <= row_mask_dec;
            col_mask <= col_mask_dec;
        end
    end

    // Row sense: drive the key's row one cycle after its column is scanned with contact closed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_out <= 4'b0000;
        end else if (contact && ((col_in & col_mask) != 4'b0000)) begin
            row_out <= row_mask;
        end else begin
            row_out <= 4'b0000;
        end
    end

    assign busy    = (state != IDLE);
    assign pressed = contact;

endmodule

// File: tb/tb_teclado_emulador.sv
// tb_teclado_emulador: two keypad emulators (no bounce / short hold, and
// default timing) driven with directed and random presses. A reference model
// built on elapsed time since accept predicts every output each cycle into a
// scoreboard queue; a monitor pops and compares on the falling edge.
module tb_teclado_emulador;

    localparam int COL_ROTATE = 0;
    localparam int COL_FIXED  = 1;
    localparam int COL_RANDOM = 2;

    typedef struct packed {
        logic       inst;
        logic [3:0] row;
        logic       busy;
        logic       done;
        logic       pressed;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start    [2];
    logic [3:0] key_code [2];
    logic [3:0] col_in   [2];
    logic [3:0] row_out  [2];
    logic       busy     [2];
    logic       done     [2];
    logic       pressed  [2];

    int         col_mode  [2];
    logic [3:0] col_fixed [2];
    int         rot_idx   [2];

    exp_t       exp_q[$];
    int         busy_run [2];
    int         n_compared;
    int         n_mismatched;

    bit         m_active [2];
    int         m_t      [2];
    logic [7:0] m_lfsr   [2];
    logic [3:0] m_row_m  [2];
    logic [3:0] m_col_m  [2];
    logic       m_done   [2];

    teclado_emulador #(.BOUNCE_CYCLES(0), .HOLD_CYCLES(8)) dut_fast (
        .clk(clk), .rst(rst), .start(start[0]), .key_code(key_code[0]),
        .col_in(col_in[0]), .row_out(row_out[0]), .busy(busy[0]),
        .done(done[0]), .pressed(pressed[0])
    );

    teclado_emulador #(.BOUNCE_CYCLES(16), .HOLD_CYCLES(64)) dut_default (
        .clk(clk), .rst(rst), .start(start[1]), .key_code(key_code[1]),
        .col_in(col_in[1]), .row_out(row_out[1]), .busy(busy[1]),
        .done(done[1]), .pressed(pressed[1])
    );

    function automatic int bc(input int i);
        return (i == 0) ? 0 : 16;
    endfunction

    function automatic int hc(input int i);
        return (i == 0) ? 8 : 64;
    endfunction

    function automatic bit in_bounce_phase(input int i, input int t);
        return (t < bc(i)) || (t >= bc(i) + hc(i));
    endfunction

    function automatic logic contact_of(input int i, input bit active, input int t, input logic [7:0] l);
        if (!active) return 1'b0;
        if (in_bounce_phase(i, t)) return l[0];
        return 1'b1;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Position of a key in the printed keypad layout, read left-to-right, top-to-bottom
    function automatic int key_index(input logic [3:0] code);
        string layout;
        byte   ch;
        layout = "123A456B789C*0#D";
        if (code <= 4'h9)      ch = byte'(8'h30 + 8'(code));
        else if (code <= 4'hD) ch = byte'(8'h41 + 8'(code) - 8'd10);
        else if (code == 4'hE) ch = byte'(8'h2A);
        else                   ch = byte'(8'h23);
        for (int k = 0; k < 16; k++) begin
            if (layout[k] == ch) return k;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int i, input logic [3:0] code, input int mode, input logic [3:0] col);
        @(negedge clk);
        col_mode[i]  = mode;
        col_fixed[i] = col;
        key_code[i]  = code;
        start[i]     = 1'b1;
        @(negedge clk);
        start[i]     = 1'b0;
    endtask

    task automatic pulseStart(input int i, input logic [3:0] code);
        @(negedge clk);
        key_code[i] = code;
        start[i]    = 1'b1;
        @(negedge clk);
        start[i]    = 1'b0;
    endtask

    task automatic waitDone(input int i, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done[i]) seen = 1'b1;
        end
        checkOutput($sformatf("done_seen_inst%0d", i), 32'(seen), 32'd1);
    endtask

    task automatic checkResetOutputs();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("reset_row_inst%0d", i), 32'(row_out[i]), 32'd0);
            checkOutput($sformatf("reset_busy_inst%0d", i), 32'(busy[i]), 32'd0);
            checkOutput($sformatf("reset_done_inst%0d", i), 32'(done[i]), 32'd0);
            checkOutput($sformatf("reset_pressed_inst%0d", i), 32'(pressed[i]), 32'd0);
        end
    endtask

    task automatic midCycleReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs();
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Column scan driver: rotating, held or random column pattern per instance
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                case (col_mode[i])
                    COL_ROTATE: begin
                        col_in[i]  = 4'b0001 << rot_idx[i];
                        rot_idx[i] = (rot_idx[i] + 1) % 4;
                    end
                    COL_FIXED: col_in[i] = col_fixed[i];
                    default:   col_in[i] = 4'($urandom_range(0, 15));
                endcase
            end
        end
    end

    // Reference model: predicts each instance's outputs after every clock edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 1'b0;
                m_t[i]      = 0;
                m_lfsr[i]   = 8'hA5;
                m_done[i]   = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic       c;
                logic [3:0] row_n;
                exp_t       e;
                int         pos;
                c = contact_of(i, m_active[i], m_t[i], m_lfsr[i]);
                row_n = (c && ((col_in[i] & m_col_m[i]) != 4'b0000)) ? m_row_m[i] : 4'b0000;
                if (m_active[i] && in_bounce_phase(i, m_t[i])) m_lfsr[i] = lfsr_step(m_lfsr[i]);
                m_done[i] = 1'b0;
                if (m_active[i]) begin
                    m_t[i] = m_t[i] + 1;
                    if (m_t[i] == 2 * bc(i) + hc(i)) begin
                        m_active[i] = 1'b0;
                        m_done[i]   = 1'b1;
                    end
                end else if (start[i]) begin
                    pos         = key_index(key_code[i]);
                    m_active[i] = 1'b1;
                    m_t[i]      = 0;
                    m_row_m[i]  = 4'b0001 << (pos / 4);
                    m_col_m[i]  = 4'b0001 << (pos % 4);
                end
                e.inst    = 1'(i);
                e.row     = row_n;
                e.busy    = m_active[i];
                e.done    = m_done[i];
                e.pressed = contact_of(i, m_active[i], m_t[i], m_lfsr[i]);
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: pops predictions and compares them, and measures busy length at each done
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            busy_run[0] = 0;
            busy_run[1] = 0;
        end else begin
            while (exp_q.size() > 0) begin
                exp_t e;
                int   i;
                e = exp_q.pop_front();
                i = int'(e.inst);
                checkOutput($sformatf("outputs_inst%0d {row,busy,done,pressed}", i),
                            32'({row_out[i], busy[i], done[i], pressed[i]}),
                            32'({e.row, e.busy, e.done, e.pressed}));
            end
            for (int i = 0; i < 2; i++) begin
                if (busy[i]) busy_run[i]++;
                if (done[i]) begin
                    checkOutput($sformatf("busy_length_inst%0d", i), 32'(busy_run[i]), 32'(2 * bc(i) + hc(i)));
                    busy_run[i] = 0;
                end
            end
        end
    end

    // Directed scenarios followed by random presses
    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i]     = 1'b0;
            key_code[i]  = 4'h0;
            col_mode[i]  = COL_FIXED;
            col_fixed[i] = 4'b1111;
            col_in[i]    = 4'b1111;
            rot_idx[i]   = 0;
            busy_run[i]  = 0;
        end
        n_compared   = 0;
        n_mismatched = 0;
        @(posedge clk);
        #1;
        checkResetOutputs();
        @(posedge clk);
        #3;
        rst = 1'b0;

        $display("[TB] press '5' with no bounce, rotating columns");
        applyStimulus(0, 4'h5, COL_ROTATE, 4'b0000);
        waitDone(0, 40);

        $display("[TB] press 'D' with default timing, column 3 held");
        applyStimulus(1, 4'hD, COL_FIXED, 4'b1000);
        waitDone(1, 200);

        $display("[TB] press '0' on its own column, then on a wrong column");
        applyStimulus(1, 4'h0, COL_FIXED, 4'b0010);
        waitDone(1, 200);
        applyStimulus(1, 4'h0, COL_FIXED, 4'b0001);
        waitDone(1, 200);

        $display("[TB] second start during hold is ignored");
        applyStimulus(1, 4'h5, COL_FIXED, 4'b0010);
        repeat (40) @(negedge clk);
        pulseStart(1, 4'h3);
        waitDone(1, 200);
        repeat (5) @(negedge clk);

        $display("[TB] reset during hold, then a fresh press");
        applyStimulus(1, 4'hD, COL_FIXED, 4'b1000);
        repeat (40) @(negedge clk);
        midCycleReset();
        applyStimulus(1, 4'hD, COL_FIXED, 4'b1000);
        waitDone(1, 200);

        $display("[TB] start held high: restart on the done cycle");
        @(negedge clk);
        col_mode[0] = COL_FIXED;
        col_fixed[0] = 4'b1111;
        key_code[0] = 4'h9;
        start[0]    = 1'b1;
        repeat (30) @(negedge clk);
        start[0]    = 1'b0;

        $display("[TB] random presses");
        for (int n = 0; n < 24; n++) begin
            int i;
            i = int'($urandom_range(0, 1));
            applyStimulus(i, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                          4'($urandom_range(0, 15)));
            repeat ($urandom_range(1, 120)) @(negedge clk);
        end
        repeat (200) @(negedge clk);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
